mem_sp_param: RTL and testbench

//   Parametrised single-port synchronous memory for general datapath storage.

---
 rtl/mem_sp_param.sv | 168 ++++++++++++++++
 tb/tb_mem_sp_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_param.sv
// Single-port synchronous RAM with byte-enable writes and a 1- or 2-cycle read latency.
// It has a self-zeroing init sequencer and flags out-of-range addresses for non-power-of-two depths.
module mem_sp_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   input  logic                  clr,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rvalid,
   output logic                  busy,
   output logic                  err
);
   localparam int BYTES = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

   state_t              state_r, state_nxt_s;
   logic [ADDR_W-1:0]   init_ptr_r, init_ptr_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic                oor_s, acc_s, wr_acc_s, rd_acc_s, err_nxt_s;
   logic [DATA_W-1:0]   rd_word_s;
   logic                rsp_v_s;
   logic [DATA_W-1:0]   rsp_d_s;
   logic                rvalid_r, err_r;
   logic [DATA_W-1:0]   rdata_r;

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("mem_sp_param: RD_LAT must be 1 or 2");
   end
   if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("mem_sp_param: DATA_W must be a multiple of 8");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("mem_sp_param: DEPTH must be at least 2");
   end

   // A full power-of-two address space can never point outside the array.
   if (DEPTH == (1 << ADDR_W)) begin : g_pow2
      assign oor_s = 1'b0;
   end else begin : g_npow2
      localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
      assign oor_s = ({1'b0, addr} >= DEPTH_L);
   end

   // Access qualification and read-word selection
   always_comb begin
      acc_s     = (state_r == ST_IDLE) && !clr && (we || re);
      wr_acc_s  = acc_s && we;
      rd_acc_s  = acc_s && re && !we;
      err_nxt_s = acc_s && (we != re) && oor_s;
      rd_word_s = oor_s ? {DATA_W{1'b0}} : mem_r[addr];
   end

   // Init sequencer next-state logic
   always_comb begin
      state_nxt_s    = state_r;
      init_ptr_nxt_s = init_ptr_r;
      busy_nxt_s     = busy_r;
      case (state_r)
         ST_INIT: begin
            if (init_ptr_r == LAST_PTR) begin
               state_nxt_s    = ST_IDLE;
               init_ptr_nxt_s = {ADDR_W{1'b0}};
               busy_nxt_s     = 1'b0;
            end else begin
               init_ptr_nxt_s = init_ptr_r + ADDR_W'(1);
               busy_nxt_s     = 1'b1;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_nxt_s    = ST_INIT;
               init_ptr_nxt_s = {ADDR_W{1'b0}};
               busy_nxt_s     = 1'b1;
            end else begin
               busy_nxt_s     = 1'b0;
            end
         end
         default: begin
            state_nxt_s    = ST_INIT;
            init_ptr_nxt_s = {ADDR_W{1'b0}};
            busy_nxt_s     = 1'b1;
         end
      endcase
   end

   // Init sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_INIT;
         init_ptr_r <= {ADDR_W{1'b0}};
         busy_r     <= 1'b1;
      end else begin
         state_r    <= state_nxt_s;
         init_ptr_r <= init_ptr_nxt_s;
         busy_r     <= busy_nxt_s;
      end
   end

   // Storage array: zeroed word-by-word during init, byte-masked writes when idle
   always_ff @(posedge clk) begin
      if (state_r == ST_INIT) begin
         mem_r[init_ptr_r] <= {DATA_W{1'b0}};
      end else if (wr_acc_s && !oor_s) begin
         for (int i = 0; i < BYTES; i++) begin
            if (be[i]) begin
               mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // The word is captured at acceptance, so a following clr cannot disturb it.
   if (RD_LAT == 2) begin : g_lat2
      logic              stg_v_r;
      logic [DATA_W-1:0] stg_d_r;

      // Extra read stage for the two-cycle latency configuration
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stg_v_r <= 1'b0;
            stg_d_r <= {DATA_W{1'b0}};
         end else begin
            stg_v_r <= rd_acc_s;
            if (rd_acc_s) begin
               stg_d_r <= rd_word_s;
            end
         end
      end

      assign rsp_v_s = stg_v_r;
      assign rsp_d_s = stg_d_r;
   end else begin : g_lat1
      assign rsp_v_s = rd_acc_s;
      assign rsp_d_s = rd_word_s;
   end

   // Output registers; rdata holds between responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_r <= 1'b0;
         rdata_r  <= {DATA_W{1'b0}};
         err_r    <= 1'b0;
      end else begin
         rvalid_r <= rsp_v_s;
         err_r    <= err_nxt_s;
         if (rsp_v_s) begin
            rdata_r <= rsp_d_s;
         end
      end
   end

   assign rdata  = rdata_r;
   assign rvalid = rvalid_r;
   assign busy   = busy_r;
   assign err    = err_r;
endmodule

// File: tb/tb_mem_sp_param.sv
// Bench for mem_sp_param: a default instance and a DEPTH=12/RD_LAT=2 instance share stimulus.
// Both are checked every cycle against a behavioural model, plus literal expectations.
module tb_mem_sp_param;
   logic        clk = 1'b0;
   logic        rst, we, re, clr;
   logic [3:0]  addr, be;
   logic [31:0] wdata;
   logic [31:0] rdata16, rdata12;
   logic        rvalid16, rvalid12, busy16, busy12, err16, err12;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   mem_sp_param dut16 (
      .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata), .be(be), .clr(clr),
      .rdata(rdata16), .rvalid(rvalid16), .busy(busy16), .err(err16)
   );

   mem_sp_param #(.DATA_W(32), .DEPTH(12), .RD_LAT(2)) dut12 (
      .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata), .be(be), .clr(clr),
      .rdata(rdata12), .rvalid(rvalid12), .busy(busy12), .err(err12)
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      int          k;
      int          due;
      logic [31:0] d;
   } resp_t;

   resp_t       rq[$];
   logic [31:0] m_mem [2][16];
   int          init_left [2];
   logic [31:0] e_rdata [2];
   logic        e_rvalid [2];
   logic        e_busy [2];
   logic        e_err [2];

   function automatic int dep(input int k);
      return (k == 0) ? 16 : 12;
   endfunction

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   task automatic model_step();
      resp_t r;
      cyc++;
      if (rst) rq.delete();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int a = 0; a < 16; a++) m_mem[k][a] = 32'd0;
            init_left[k] = dep(k);
            e_rdata[k]   = 32'd0;
            e_rvalid[k]  = 1'b0;
            e_err[k]     = 1'b0;
         end else begin
            e_err[k] = 1'b0;
            if (init_left[k] > 0) begin
               init_left[k]--;
            end else if (clr) begin
               for (int a = 0; a < 16; a++) m_mem[k][a] = 32'd0;
               init_left[k] = dep(k);
            end else if (we) begin
               if (int'(addr) < dep(k)) begin
                  for (int b = 0; b < 4; b++)
                     if (be[b]) m_mem[k][addr][8*b +: 8] = wdata[8*b +: 8];
               end
               e_err[k] = (int'(addr) >= dep(k)) && !re;
            end else if (re) begin
               r.k   = k;
               r.due = cyc + lat(k) - 1;
               r.d   = (int'(addr) < dep(k)) ? m_mem[k][addr] : 32'd0;
               rq.push_back(r);
               e_err[k] = (int'(addr) >= dep(k));
            end
            e_rvalid[k] = 1'b0;
            for (int i = 0; i < rq.size(); i++) begin
               if (rq[i].k == k && rq[i].due == cyc) begin
                  e_rvalid[k] = 1'b1;
                  e_rdata[k]  = rq[i].d;
                  rq.delete(i);
                  break;
               end
            end
         end
         e_busy[k] = (init_left[k] > 0);
      end
   endtask

   task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", nm, (k == 0) ? 16 : 12, cyc, act, exp);
      end
   endtask

   // Model update on each rising edge, then compare just after the edge
   always @(posedge clk) begin
      model_step();
      #1;
      cmp("rdata",  0, rdata16,          e_rdata[0]);
      cmp("rvalid", 0, 32'(rvalid16),    32'(e_rvalid[0]));
      cmp("busy",   0, 32'(busy16),      32'(e_busy[0]));
      cmp("err",    0, 32'(err16),       32'(e_err[0]));
      cmp("rdata",  1, rdata12,          e_rdata[1]);
      cmp("rvalid", 1, 32'(rvalid12),    32'(e_rvalid[1]));
      cmp("busy",   1, 32'(busy12),      32'(e_busy[1]));
      cmp("err",    1, 32'(err12),       32'(e_err[1]));
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      we = 1'b0; re = 1'b0; clr = 1'b0; addr = 4'd0; wdata = 32'd0; be = 4'd0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drv(input logic w, input logic r, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] b);
      we = w; re = r; clr = 1'b0; addr = a; wdata = d; be = b;
      @(negedge clk);
   endtask

   task automatic count_busy(output int n16, output int n12);
      n16 = 0;
      n12 = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy16) n16++;
         if (busy12) n12++;
         @(negedge clk);
      end
   endtask

   int n16, n12, c16, c12;

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) step();
      cmp("rst_rvalid", 0, 32'(rvalid16), 32'd0);
      cmp("rst_rdata",  0, rdata16,       32'd0);
      cmp("rst_busy",   0, 32'(busy16),   32'd1);
      cmp("rst_err",    0, 32'(err16),    32'd0);
      rst = 1'b0;
      count_busy(n16, n12);
      cmp("init_len", 0, 32'(n16), 32'd16);
      cmp("init_len", 1, 32'(n12), 32'd12);

      // all words read back zero, rvalid one cycle after re
      for (int a = 0; a < 16; a++) begin
         drv(1'b0, 1'b1, 4'(a), 32'd0, 4'd0);
         cmp("t1_rvalid", 0, 32'(rvalid16), 32'd1);
         cmp("t1_rdata",  0, rdata16,       32'd0);
      end
      idle();
      repeat (3) step();

      // byte-enable merge
      drv(1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 4'hF);
      drv(1'b1, 1'b0, 4'd5, 32'h000000AA, 4'h1);
      drv(1'b0, 1'b1, 4'd5, 32'd0, 4'd0);
      cmp("t2_rdata",  0, rdata16,       32'hDEADBEAA);
      cmp("t2_rvalid", 0, 32'(rvalid16), 32'd1);
      idle();
      step();
      cmp("t2_rdata",  1, rdata12,       32'hDEADBEAA);
      cmp("t2_rvalid", 1, 32'(rvalid12), 32'd1);

      // write wins over simultaneous read; back-to-back reads
      drv(1'b1, 1'b1, 4'd3, 32'h12345678, 4'hF);
      cmp("t3_no_rvalid", 0, 32'(rvalid16), 32'd0);
      drv(1'b0, 1'b1, 4'd3, 32'd0, 4'd0);
      cmp("t3_rdata", 0, rdata16, 32'h12345678);
      idle();
      repeat (2) step();
      c16 = 0;
      c12 = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            we = 1'b0; re = 1'b1; addr = 4'(i);
         end else begin
            idle();
         end
         step();
         if (rvalid16) c16++;
         if (rvalid12) c12++;
      end
      cmp("t3_burst", 0, 32'(c16), 32'd4);
      cmp("t3_burst", 1, 32'(c12), 32'd4);

      // out-of-range on the 12-deep instance
      drv(1'b1, 1'b0, 4'd13, 32'h55555555, 4'hF);
      cmp("t4_werr", 1, 32'(err12), 32'd1);
      drv(1'b0, 1'b1, 4'd13, 32'd0, 4'd0);
      cmp("t4_rerr",     1, 32'(err12),    32'd1);
      cmp("t4_rv_early", 1, 32'(rvalid12), 32'd0);
      idle();
      step();
      cmp("t4_rvalid", 1, 32'(rvalid12), 32'd1);
      cmp("t4_rdata",  1, rdata12,       32'd0);
      drv(1'b0, 1'b1, 4'd11, 32'd0, 4'd0);
      idle();
      repeat (3) step();

      // read just before clr returns old data; clr re-zeroes array
      for (int a = 0; a < 16; a++) drv(1'b1, 1'b0, 4'(a), 32'hC0DE0000 + 32'(a), 4'hF);
      drv(1'b0, 1'b1, 4'd7, 32'd0, 4'd0);
      cmp("t5_old", 0, rdata16, 32'hC0DE0007);
      idle();
      clr = 1'b1;
      step();
      cmp("t5_old_rv", 1, 32'(rvalid12), 32'd1);
      cmp("t5_old",    1, rdata12,       32'hC0DE0007);
      idle();
      count_busy(n16, n12);
      cmp("t5_busy_len", 0, 32'(n16), 32'd16);
      cmp("t5_busy_len", 1, 32'(n12), 32'd12);
      for (int a = 0; a < 16; a++) begin
         drv(1'b0, 1'b1, 4'(a), 32'd0, 4'd0);
         if (a == 7) cmp("t5_cleared", 0, rdata16, 32'd0);
      end
      idle();
      repeat (3) step();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         we    = ($urandom_range(0, 3) == 0);
         re    = ($urandom_range(0, 2) == 0);
         addr  = 4'($urandom_range(0, 15));
         wdata = $urandom();
         be    = 4'($urandom_range(0, 15));
         clr   = ($urandom_range(0, 79) == 0);
         step();
      end
      idle();
      repeat (20) step();

      // async reset in the middle of a read burst
      drv(1'b1, 1'b0, 4'd2, 32'h0BADF00D, 4'hF);
      we = 1'b0; re = 1'b1; addr = 4'd2;
      repeat (3) step();
      @(posedge clk);
      #1;
      cmp("t6_pre_rvalid", 0, 32'(rvalid16), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      cmp("t6_rvalid", 0, 32'(rvalid16), 32'd0);
      cmp("t6_rdata",  0, rdata16,       32'd0);
      cmp("t6_rvalid", 1, 32'(rvalid12), 32'd0);
      cmp("t6_rdata",  1, rdata12,       32'd0);
      cmp("t6_busy",   0, 32'(busy16),   32'd1);
      idle();
      repeat (2) step();
      rst = 1'b0;
      count_busy(n16, n12);
      cmp("t6_init_len", 0, 32'(n16), 32'd16);
      cmp("t6_init_len", 1, 32'(n12), 32'd12);

      // async reset in the middle of a clr-triggered init
      clr = 1'b1;
      step();
      idle();
      repeat (5) step();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      cmp("t6_midinit_busy", 0, 32'(busy16), 32'd1);
      repeat (2) step();
      rst = 1'b0;
      count_busy(n16, n12);
      cmp("t6_rerun_len", 0, 32'(n16), 32'd16);
      cmp("t6_rerun_len", 1, 32'(n12), 32'd12);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
